// File: rtl/inst_buffer_pkg.sv
// Shared packet types and default sizing for the fetch-to-dispatch instruction buffer.
package inst_buffer_pkg;

  localparam int IB_DEPTH    = 8;
  localparam int IB_IF_WIDTH = 2;
  localparam int IB_DP_WIDTH = 2;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } if_ib_packet_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
  } ib_dp_packet_t;

  localparam int IB_PKT_W = $bits(if_ib_packet_t);

endpackage

// File: rtl/inst_buffer.sv
// Circular instruction FIFO between fetch and dispatch; up to IF_WIDTH in, DP_WIDTH presented oldest-first.
// Push-to-present latency 1 cycle, no bypass; excess pushes beyond free space drop, dispatch pops via accept count.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH    = IB_DEPTH,
  parameter int IF_WIDTH = IB_IF_WIDTH,
  parameter int DP_WIDTH = IB_DP_WIDTH
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              squash,
  input  logic [IF_WIDTH*IB_PKT_W-1:0]      if_packet,
  output logic [$clog2(DEPTH+1)-1:0]        ib_free_slots,
  output logic [DP_WIDTH*IB_PKT_W-1:0]      ib_dp_packet,
  input  logic [$clog2(DP_WIDTH+1)-1:0]     dp_accept_count,
  output logic                              ib_empty,
  output logic                              ib_full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(IF_WIDTH + 1);

  if_ib_packet_t [IF_WIDTH-1:0] if_pkt;
  ib_dp_packet_t [DP_WIDTH-1:0] dp_pkt;
  ib_dp_packet_t                mem [DEPTH];

  logic [PW-1:0] head, tail;
  logic [CW-1:0] count, space, push_n, avail, pop_n;
  logic [IW-1:0] push_req;
  logic          seen_gap;

  assign if_pkt       = if_packet;
  assign ib_dp_packet = dp_pkt;

  // Only the contiguous run of valid slots starting at slot 0 is taken.
  always_comb begin
    push_req = '0;
    seen_gap = 1'b0;
    for (int i = 0; i < IF_WIDTH; i++) begin
      if (!if_pkt[i].valid) seen_gap = 1'b1;
      else if (!seen_gap)   push_req = IW'(i + 1);
    end
  end

  // Space uses cycle-start count, so slots freed by a same-cycle pop wait a cycle.
  assign space  = CW'(DEPTH) - count;
  assign push_n = (CW'(push_req) < space) ? CW'(push_req) : space;
  assign avail  = (count < CW'(DP_WIDTH)) ? count : CW'(DP_WIDTH);
  assign pop_n  = (CW'(dp_accept_count) < avail) ? CW'(dp_accept_count) : avail;

  always_comb begin
    for (int i = 0; i < DP_WIDTH; i++) begin
      dp_pkt[i] = '0;
      if (CW'(i) < avail) begin
        dp_pkt[i]       = mem[head + PW'(i)];
        dp_pkt[i].valid = 1'b1;
      end
    end
  end

  assign ib_free_slots = space;
  assign ib_empty      = (count == '0);
  assign ib_full       = (count == CW'(DEPTH));

  always_ff @(posedge clock) begin
    if (!squash) begin
      for (int i = 0; i < IF_WIDTH; i++) begin
        if (CW'(i) < push_n) mem[tail + PW'(i)] <= if_pkt[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (squash) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + PW'(push_n);
      head  <= head + PW'(pop_n);
      count <= count + push_n - pop_n;
    end
  end

  // Dispatch may not consume entries that were never presented.
  assert property (@(posedge clock) disable iff (!reset)
                   (ib_empty || CW'(dp_accept_count) <= avail));

endmodule

// File: tb/tb_inst_buffer.sv
// Table-driven directed sequences plus randomized traffic against a queue-based reference model.
module tb_inst_buffer;
  import inst_buffer_pkg::*;

  localparam int DEPTH = 8;
  localparam int IFW   = 2;
  localparam int DPW   = 2;
  localparam int PW    = IB_PKT_W;

  logic               clock = 1'b0;
  logic               reset;
  logic               squash;
  logic [IFW*PW-1:0]  if_packet;
  logic [3:0]         ib_free_slots;
  logic [DPW*PW-1:0]  ib_dp_packet;
  logic [1:0]         dp_accept_count;
  logic               ib_empty, ib_full;

  int n_tests = 0;
  int n_fail  = 0;

  if_ib_packet_t q[$];
  if_ib_packet_t in_pkt[IFW];
  int            acc;
  bit            sq;

  typedef struct {
    logic [31:0] pc0; bit v0; logic [31:0] pc1; bit v1; int acc; bit sq;
    int e_free; bit e_empty; bit e_full;
    logic [31:0] e_pc0; bit e_v0; logic [31:0] e_pc1; bit e_v1;
  } vec_t;
  vec_t tbl[24];

  always #5 clock = ~clock;

  inst_buffer #(.DEPTH(DEPTH), .IF_WIDTH(IFW), .DP_WIDTH(DPW)) dut (
    .clock(clock), .reset(reset), .squash(squash), .if_packet(if_packet),
    .ib_free_slots(ib_free_slots), .ib_dp_packet(ib_dp_packet),
    .dp_accept_count(dp_accept_count), .ib_empty(ib_empty), .ib_full(ib_full)
  );

  function automatic if_ib_packet_t mk(input logic [31:0] pc, input bit v);
    if_ib_packet_t p;
    p.inst  = pc ^ 32'h1357_9bdf;
    p.pc    = pc;
    p.npc   = pc + 32'd4;
    p.valid = v;
    return p;
  endfunction

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic drive();
    if_packet       = {in_pkt[1], in_pkt[0]};
    dp_accept_count = acc[1:0];
    squash          = sq;
  endtask

  task automatic check_model(input string tag);
    if_ib_packet_t exp;
    if_ib_packet_t act;
    for (int i = 0; i < DPW; i++) begin
      exp = (i < q.size()) ? q[i] : '0;
      act = ib_dp_packet[i*PW +: PW];
      check($sformatf("%s slot%0d", tag, i), 128'(act), 128'(exp));
    end
    check({tag, " free"}, 128'(ib_free_slots), 128'(DEPTH - q.size()));
    check({tag, " empty/full"}, 128'({ib_empty, ib_full}),
          128'({q.size() == 0, q.size() == DEPTH}));
  endtask

  // Reference: leading valid slots fit into cycle-start free space; pop at most what was shown.
  task automatic model_update();
    int  req, pushn, popn, avail;
    bit  gap;
    req = 0; gap = 0;
    for (int i = 0; i < IFW; i++) begin
      if (!in_pkt[i].valid) gap = 1;
      else if (!gap) req++;
    end
    pushn = (req < DEPTH - q.size()) ? req : DEPTH - q.size();
    avail = (q.size() < DPW) ? q.size() : DPW;
    popn  = (acc < avail) ? acc : avail;
    if (sq) q.delete();
    else begin
      repeat (popn) void'(q.pop_front());
      for (int i = 0; i < pushn; i++) q.push_back(in_pkt[i]);
    end
  endtask

  task automatic step(input string tag);
    drive();
    check_model(tag);
    @(posedge clock);
    model_update();
    #1;
  endtask

  initial begin
    if_ib_packet_t exp0, exp1;
    tbl[0]  = '{32'h0,   1, 32'h4,   1, 0, 0, 6, 0, 0, 32'h0,   1, 32'h4,   1};
    tbl[1]  = '{32'h0,   0, 32'h0,   0, 1, 0, 7, 0, 0, 32'h4,   1, 32'h0,   0};
    tbl[2]  = '{32'h0,   0, 32'h0,   0, 1, 0, 8, 1, 0, 32'h0,   0, 32'h0,   0};
    tbl[3]  = '{32'h0,   1, 32'h4,   1, 0, 0, 6, 0, 0, 32'h0,   1, 32'h4,   1};
    tbl[4]  = '{32'h8,   1, 32'hc,   1, 0, 0, 4, 0, 0, 32'h0,   1, 32'h4,   1};
    tbl[5]  = '{32'h10,  1, 32'h14,  1, 0, 0, 2, 0, 0, 32'h0,   1, 32'h4,   1};
    tbl[6]  = '{32'h18,  1, 32'h1c,  1, 0, 0, 0, 0, 1, 32'h0,   1, 32'h4,   1};
    tbl[7]  = '{32'h20,  1, 32'h24,  1, 0, 0, 0, 0, 1, 32'h0,   1, 32'h4,   1};
    tbl[8]  = '{32'h0,   0, 32'h0,   0, 2, 0, 2, 0, 0, 32'h8,   1, 32'hc,   1};
    tbl[9]  = '{32'h28,  1, 32'h2c,  1, 0, 0, 0, 0, 1, 32'h8,   1, 32'hc,   1};
    tbl[10] = '{32'h40,  1, 32'h44,  1, 2, 0, 2, 0, 0, 32'h10,  1, 32'h14,  1};
    tbl[11] = '{32'h0,   0, 32'h0,   0, 2, 0, 4, 0, 0, 32'h18,  1, 32'h1c,  1};
    tbl[12] = '{32'h0,   0, 32'h0,   0, 2, 0, 6, 0, 0, 32'h28,  1, 32'h2c,  1};
    tbl[13] = '{32'h0,   0, 32'h0,   0, 2, 0, 8, 1, 0, 32'h0,   0, 32'h0,   0};
    tbl[14] = '{32'h50,  1, 32'h54,  0, 0, 0, 7, 0, 0, 32'h50,  1, 32'h0,   0};
    tbl[15] = '{32'h58,  1, 32'h5c,  1, 1, 0, 6, 0, 0, 32'h58,  1, 32'h5c,  1};
    tbl[16] = '{32'h100, 1, 32'h104, 1, 2, 0, 6, 0, 0, 32'h100, 1, 32'h104, 1};
    tbl[17] = '{32'h0,   0, 32'h0,   0, 2, 0, 8, 1, 0, 32'h0,   0, 32'h0,   0};
    tbl[18] = '{32'h200, 1, 32'h204, 1, 0, 0, 6, 0, 0, 32'h200, 1, 32'h204, 1};
    tbl[19] = '{32'h208, 1, 32'h20c, 1, 0, 0, 4, 0, 0, 32'h200, 1, 32'h204, 1};
    tbl[20] = '{32'h210, 1, 32'h214, 0, 0, 0, 3, 0, 0, 32'h200, 1, 32'h204, 1};
    tbl[21] = '{32'h300, 1, 32'h304, 1, 2, 1, 8, 1, 0, 32'h0,   0, 32'h0,   0};
    tbl[22] = '{32'h0,   0, 32'h400, 1, 0, 0, 8, 1, 0, 32'h0,   0, 32'h0,   0};
    tbl[23] = '{32'h500, 1, 32'h504, 1, 0, 0, 6, 0, 0, 32'h500, 1, 32'h504, 1};

    // Reset held low with garbage on every input.
    reset     = 1'b0;
    in_pkt[0] = mk($urandom, 1);
    in_pkt[1] = mk($urandom, 1);
    acc = 3; sq = 1'b1;
    drive();
    repeat (2) @(posedge clock);
    #1;
    check("reset free", 128'(ib_free_slots), 128'(8));
    check("reset empty/full", 128'({ib_empty, ib_full}), 128'(2'b10));
    check("reset packets", 128'(ib_dp_packet), 128'(0));
    in_pkt[0] = mk(0, 0); in_pkt[1] = mk(0, 0); acc = 0; sq = 0;
    drive();
    reset = 1'b1;
    step("idle0");
    step("idle1");

    for (int r = 0; r < 24; r++) begin
      in_pkt[0] = mk(tbl[r].pc0, tbl[r].v0);
      in_pkt[1] = mk(tbl[r].pc1, tbl[r].v1);
      acc = tbl[r].acc; sq = tbl[r].sq;
      step($sformatf("row%0d pre", r));
      exp0 = tbl[r].e_v0 ? mk(tbl[r].e_pc0, 1) : '0;
      exp1 = tbl[r].e_v1 ? mk(tbl[r].e_pc1, 1) : '0;
      check($sformatf("row%0d slot0", r), 128'(ib_dp_packet[0 +: PW]), 128'(exp0));
      check($sformatf("row%0d slot1", r), 128'(ib_dp_packet[PW +: PW]), 128'(exp1));
      check($sformatf("row%0d free", r), 128'(ib_free_slots), 128'(tbl[r].e_free));
      check($sformatf("row%0d empty/full", r), 128'({ib_empty, ib_full}),
            128'({tbl[r].e_empty, tbl[r].e_full}));
    end

    for (int c = 0; c < 400; c++) begin
      int lim;
      in_pkt[0] = mk({$urandom_range(0, 16'hffff), 2'b00}, $urandom_range(0, 3) != 0);
      in_pkt[1] = mk({$urandom_range(0, 16'hffff), 2'b00}, $urandom_range(0, 1) == 1);
      lim = (q.size() < DPW) ? q.size() : DPW;
      if (q.size() == 0) acc = $urandom_range(0, 2);
      else acc = ($urandom_range(0, 2) == 0) ? lim : $urandom_range(0, lim);
      sq = ($urandom_range(0, 31) == 0);
      step($sformatf("rnd%0d", c));
    end

    // Asynchronous reset asserted mid-cycle with contents present.
    in_pkt[0] = mk(32'h700, 1); in_pkt[1] = mk(32'h704, 1); acc = 0; sq = 0;
    step("pre-arst");
    in_pkt[0] = mk(0, 0); in_pkt[1] = mk(0, 0);
    drive();
    #2;
    reset = 1'b0;
    #1;
    q.delete();
    check("arst free", 128'(ib_free_slots), 128'(8));
    check("arst empty/full", 128'({ib_empty, ib_full}), 128'(2'b10));
    check("arst packets", 128'(ib_dp_packet), 128'(0));
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_pkt[0] = mk(32'h800, 1); in_pkt[1] = mk(32'h804, 1);
    step("post-arst push");
    in_pkt[0] = mk(0, 0); in_pkt[1] = mk(0, 0);
    step("post-arst check");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
